serial_mag_compare: RTL
=======================

SERIAL_MAG_COMPARE -- requirements
Module: serial_mag_compare

Interface
REQ-001 Parameter: WIDTH, 8, expected bits per word (legal 1..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  a bit-result beat is present this cycle.
REQ-005 Port: in_first  input  1  beat is the MSB of a new word; qualified by in_valid.
REQ-006 Port: in_last  input  1  beat is the LSB of the current word; qualified by in_valid.
REQ-007 Port: e  input  1  upstream 1-bit comparator: bits equal.
REQ-008 Port: g  input  1  upstream 1-bit comparator: a bit greater than b bit.
REQ-009 Port: l  input  1  upstream 1-bit comparator: a bit less than b bit.
REQ-010 Port: out_valid  output  1  one-cycle pulse: word result is valid.
REQ-011 Port: out_eq  output  1  word a == word b.
REQ-012 Port: out_gt  output  1  word a > word b.
REQ-013 Port: out_lt  output  1  word a < word b.
REQ-014 Port: len_err  output  1  completed word length differed from WIDTH; valid with out_valid.
REQ-015 Port: busy  output  1  a word is in progress (state not IDLE).

Function
REQ-016 Beats arrive MSB first; a beat is accepted on any cycle with in_valid=1; there is no backpressure.
REQ-017 FSM states: IDLE, EQUAL (all bits so far equal), RESOLVED (first unequal bit found; verdict frozen).
REQ-018 Accepted beat with in_first=1, in any state, starts a new word: counter=1, beat evaluated as in EQUAL; any partial word is discarded without out_valid.
REQ-019 Accepted beat in IDLE without in_first: ignored entirely.
REQ-020 In EQUAL: g=1 -> RESOLVED with verdict GT; else l=1 -> RESOLVED with verdict LT; else remain EQUAL.
REQ-021 In RESOLVED: e/g/l ignored; verdict unchanged until word ends.
REQ-022 Each accepted in-word beat increments a bit counter that saturates at 63.
REQ-023 Accepted beat with in_last=1 (in_first may also be 1, giving a 1-bit word): on the next cycle out_valid=1 for exactly one cycle, state -> IDLE.
REQ-024 Result outputs are registered, exactly one of out_eq/out_gt/out_lt is 1 with out_valid, and they hold their value until the next word completes.
REQ-025 len_err=1 with out_valid iff final count != WIDTH; the result is still reported; len_err holds like the result outputs.
REQ-026 Back-to-back words: an in_first beat on the cycle out_valid is high is accepted with no bubble.
REQ-027 busy=1 from the cycle after an in_first beat until the cycle after the in_last beat.

Reset
REQ-028 rst_n=0 immediately forces state IDLE, counter 0, and out_valid, out_eq, out_gt, out_lt, len_err, busy all 0.
REQ-029 Reset asserted mid-word discards the word; no out_valid is produced for it after release.

Configuration
REQ-030 Macro SERIAL_CMP_ONEHOT_CHK_EN, when defined, adds output port onehot_err (1 bit).
REQ-031 With the macro: an in-word beat whose e/g/l is not exactly one-hot marks the word bad; at completion out_valid=1, out_eq=out_gt=out_lt=0, onehot_err=1.
REQ-032 Without the macro: no onehot_err port; priority is g over l over e, and a beat with all three 0 is treated as equal.

Verification
REQ-033 WIDTH=8, beats e,e,g,l,l,e,e,e (first on beat 0, last on beat 7) -> one cycle after last: out_valid=1, out_gt=1, len_err=0.
REQ-034 8 beats all e -> out_eq=1; then 8 beats l,g,... with in_first on the out_valid cycle -> second out_valid eight cycles later with out_lt=1.
REQ-035 5-beat word e,e,e,e,l (WIDTH=8) -> out_valid=1, out_lt=1, len_err=1.
REQ-036 rst_n=0 after beat 3 of a word, release, then idle beats without in_first -> no out_valid, busy=0, all outputs 0.
REQ-037 Beats e,g,e then a new in_first beat, then 7 more e beats with last on the 8th beat of the new word -> no result for the aborted word, final out_eq=1.
REQ-038 With SERIAL_CMP_ONEHOT_CHK_EN: beat with g=l=1 in an 8-beat word -> out_valid=1, onehot_err=1, out_eq=out_gt=out_lt=0.

Source files
------------

// File: rtl/serial_mag_compare.sv
// Serial magnitude comparator: folds MSB-first 1-bit compare beats (e/g/l) into a word verdict.
// Latency: verdict registered, out_valid pulses the cycle after the in_last beat.
// Backpressure: none; every in_valid beat is consumed, an in_first beat may land on the out_valid cycle.
//
// Ports: clk/rst_n (async active-low); in_valid/in_first/in_last frame the beats; e/g/l are the
// per-bit compare results; out_valid/out_eq/out_gt/out_lt/len_err report the word; busy = word open.
// Optional macro SERIAL_CMP_ONEHOT_CHK_EN adds onehot_err, flagging words with a non-one-hot e/g/l beat.
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_first,
    input  logic in_last,
    input  logic e,
    input  logic g,
    input  logic l,
    output logic out_valid,
    output logic out_eq,
    output logic out_gt,
    output logic out_lt,
    output logic len_err,
`ifdef SERIAL_CMP_ONEHOT_CHK_EN
    output logic onehot_err,
`endif
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EQUAL    = 2'd1,
        RESOLVED = 2'd2
    } state_t;

    localparam logic [5:0] CNT_MAX = 6'd63;
    localparam logic [5:0] WIDTH_C = 6'(WIDTH);

    state_t     state_q, state_d;
    state_t     word_st;        // state after evaluating this beat, before word completion
    logic [5:0] cnt_q, cnt_d;
    logic       gt_q, gt_d;     // frozen verdict once RESOLVED: 1 = a>b, 0 = a<b
    logic       done;
    logic       take;
    logic       bit_eq;

    // A beat with no g/l asserted counts as equal even if e is also low.
    assign bit_eq = e | ~(g | l);
    // Beats outside a word are dropped unless they open a new one.
    assign take   = in_valid & (in_first | (state_q != IDLE));

`ifdef SERIAL_CMP_ONEHOT_CHK_EN
    logic bad_q, bad_d;
    logic beat_onehot;
    assign beat_onehot = (e ^ g ^ l) & ~(e & g & l);
`endif

    always_comb begin
        word_st = state_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        done    = 1'b0;
`ifdef SERIAL_CMP_ONEHOT_CHK_EN
        bad_d   = bad_q;
`endif
        if (take) begin
            if (in_first) begin
                // Restart: any partial word is silently discarded.
                cnt_d   = 6'd1;
                word_st = EQUAL;
`ifdef SERIAL_CMP_ONEHOT_CHK_EN
                bad_d   = 1'b0;
`endif
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 6'd1;
            end

            // Only the first differing bit (MSB side) decides; later bits are ignored.
            if (word_st == EQUAL) begin
                if (g) begin
                    word_st = RESOLVED;
                    gt_d    = 1'b1;
                end else if (l) begin
                    word_st = RESOLVED;
                    gt_d    = 1'b0;
                end else if (bit_eq) begin
                    word_st = EQUAL;
                end
            end

`ifdef SERIAL_CMP_ONEHOT_CHK_EN
            bad_d = bad_d | ~beat_onehot;
`endif
            if (in_last) begin
                done    = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = word_st;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            gt_q       <= 1'b0;
            out_valid  <= 1'b0;
            out_eq     <= 1'b0;
            out_gt     <= 1'b0;
            out_lt     <= 1'b0;
            len_err    <= 1'b0;
`ifdef SERIAL_CMP_ONEHOT_CHK_EN
            bad_q      <= 1'b0;
            onehot_err <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gt_q      <= gt_d;
            out_valid <= done;
`ifdef SERIAL_CMP_ONEHOT_CHK_EN
            bad_q     <= bad_d;
`endif
            // Result outputs only move when a word completes, so they hold between words.
            if (done) begin
                len_err <= (cnt_d != WIDTH_C);
`ifdef SERIAL_CMP_ONEHOT_CHK_EN
                onehot_err <= bad_d;
                out_eq     <= ~bad_d & (word_st == EQUAL);
                out_gt     <= ~bad_d & (word_st == RESOLVED) & gt_d;
                out_lt     <= ~bad_d & (word_st == RESOLVED) & ~gt_d;
`else
                out_eq     <= (word_st == EQUAL);
                out_gt     <= (word_st == RESOLVED) & gt_d;
                out_lt     <= (word_st == RESOLVED) & ~gt_d;
`endif
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule
